// File: rtl/mem_wb_reg_pkg.sv
// rtl/mem_wb_reg_pkg.sv - shared CPU constants and write-back select encodings
package mem_wb_reg_pkg;

  localparam int DW_DEF    = 32;
  localparam int RAW_DEF   = 5;
  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'b00,
    WB_SEL_MEM = 2'b01,
    WB_SEL_PC4 = 2'b10,
    WB_SEL_RSV = 2'b11
  } wb_sel_e;

endpackage

// File: rtl/mem_wb_reg_wb_mux.sv
// rtl/mem_wb_reg_wb_mux.sv - 4:1 MemtoReg write-back select, shared with forwarding
module wb_mux
  import mem_wb_reg_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [1:0]    sel_i,
  input  logic [DW-1:0] alu_i,
  input  logic [DW-1:0] mem_i,
  input  logic [DW-1:0] pc4_i,
  output logic [DW-1:0] data_o
);

  // Reserved encoding falls back to the ALU result so the bus never goes X.
  always_comb begin
    data_o = alu_i;
    case (wb_sel_e'(sel_i))
      WB_SEL_MEM: data_o = mem_i;
      WB_SEL_PC4: data_o = pc4_i;
      default:    data_o = alu_i;
    endcase
  end

endmodule

// File: rtl/mem_wb_reg.sv
// rtl/mem_wb_reg.sv - MEM/WB pipeline register with write-back select and retire counter
module mem_wb_reg
  import mem_wb_reg_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int RAW   = RAW_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             cnt_clr,
  input  logic             MEM_Valid,
  input  logic             MEM_RegWr,
  input  logic [1:0]       MEM_MemtoReg,
  input  logic [RAW-1:0]   MEM_Rd,
  input  logic [DW-1:0]    ALU_OUT,
  input  logic [DW-1:0]    DATAMEM_READ,
  input  logic [DW-1:0]    MEM_PC4,
  output logic             WB_Valid,
  output logic             WB_RegWr,
  output logic [RAW-1:0]   WB_Rd,
  output logic [DW-1:0]    WB_DATA,
  output logic             FWD_En,
  output logic [RAW-1:0]   FWD_Rd,
  output logic [DW-1:0]    FWD_Data,
  output logic [CNT_W-1:0] RETIRE_CNT
);

  logic             valid_q, valid_d;
  logic             regwr_q, regwr_d;
  logic [1:0]       sel_q, sel_d;
  logic [RAW-1:0]   rd_q, rd_d;
  logic [DW-1:0]    alu_q, alu_d;
  logic [DW-1:0]    mem_q, mem_d;
  logic [DW-1:0]    pc4_q, pc4_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    valid_d = valid_q;
    regwr_d = regwr_q;
    sel_d   = sel_q;
    rd_d    = rd_q;
    alu_d   = alu_q;
    mem_d   = mem_q;
    pc4_d   = pc4_q;
    if (flush) begin
      valid_d = 1'b0;
      regwr_d = 1'b0;
      sel_d   = 2'b00;
      rd_d    = '0;
      alu_d   = '0;
      mem_d   = '0;
      pc4_d   = '0;
    end else if (!stall) begin
      valid_d = MEM_Valid;
      regwr_d = MEM_RegWr & MEM_Valid;
      sel_d   = MEM_MemtoReg;
      rd_d    = MEM_Rd;
      alu_d   = ALU_OUT;
      mem_d   = DATAMEM_READ;
      pc4_d   = MEM_PC4;
    end
  end

  // Clear wins over a same-cycle retire; counter wraps naturally.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (MEM_Valid && !stall && !flush) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      regwr_q <= 1'b0;
      sel_q   <= 2'b00;
      rd_q    <= '0;
      alu_q   <= '0;
      mem_q   <= '0;
      pc4_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      regwr_q <= regwr_d;
      sel_q   <= sel_d;
      rd_q    <= rd_d;
      alu_q   <= alu_d;
      mem_q   <= mem_d;
      pc4_q   <= pc4_d;
      cnt_q   <= cnt_d;
    end
  end

  wb_mux #(.DW(DW)) u_wb_mux (
    .sel_i  (sel_q),
    .alu_i  (alu_q),
    .mem_i  (mem_q),
    .pc4_i  (pc4_q),
    .data_o (WB_DATA)
  );

  assign WB_Valid   = valid_q;
  assign WB_RegWr   = valid_q & regwr_q & (rd_q != '0);
  assign WB_Rd      = rd_q;
  assign FWD_En     = WB_RegWr;
  assign FWD_Rd     = rd_q;
  assign FWD_Data   = WB_DATA;
  assign RETIRE_CNT = cnt_q;

endmodule

// File: tb/tb_mem_wb_reg.sv
// tb/tb_mem_wb_reg.sv - directed vector bench for mem_wb_reg
module tb_mem_wb_reg;

  localparam int DW    = 32;
  localparam int RAW   = 5;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             stall, flush, cnt_clr;
  logic             MEM_Valid, MEM_RegWr;
  logic [1:0]       MEM_MemtoReg;
  logic [RAW-1:0]   MEM_Rd;
  logic [DW-1:0]    ALU_OUT, DATAMEM_READ, MEM_PC4;
  logic             WB_Valid, WB_RegWr, FWD_En;
  logic [RAW-1:0]   WB_Rd, FWD_Rd;
  logic [DW-1:0]    WB_DATA, FWD_Data;
  logic [CNT_W-1:0] RETIRE_CNT;

  int checks = 0;
  int errors = 0;

  mem_wb_reg #(.DW(DW), .RAW(RAW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .MEM_Valid(MEM_Valid), .MEM_RegWr(MEM_RegWr), .MEM_MemtoReg(MEM_MemtoReg),
    .MEM_Rd(MEM_Rd), .ALU_OUT(ALU_OUT), .DATAMEM_READ(DATAMEM_READ), .MEM_PC4(MEM_PC4),
    .WB_Valid(WB_Valid), .WB_RegWr(WB_RegWr), .WB_Rd(WB_Rd), .WB_DATA(WB_DATA),
    .FWD_En(FWD_En), .FWD_Rd(FWD_Rd), .FWD_Data(FWD_Data), .RETIRE_CNT(RETIRE_CNT)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           v, w;
    logic [1:0]     sel;
    logic [RAW-1:0] rd;
    logic [DW-1:0]  alu, mem, pc4;
    logic           st, fl, clr;
    logic           e_v, e_w;
    logic [RAW-1:0] e_rd;
    logic [DW-1:0]  e_data;
    logic [CNT_W-1:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic ew,
                            input logic [RAW-1:0] erd, input logic [DW-1:0] edata,
                            input logic [CNT_W-1:0] ecnt);
    chk({tag, "_valid"}, 64'(WB_Valid), 64'(ev));
    chk({tag, "_regwr"}, 64'(WB_RegWr), 64'(ew));
    chk({tag, "_rd"},    64'(WB_Rd),    64'(erd));
    chk({tag, "_data"},  64'(WB_DATA),  64'(edata));
    chk({tag, "_fwden"}, 64'(FWD_En),   64'(ew));
    chk({tag, "_fwdrd"}, 64'(FWD_Rd),   64'(erd));
    chk({tag, "_fwdd"},  64'(FWD_Data), 64'(edata));
    chk({tag, "_cnt"},   64'(RETIRE_CNT), 64'(ecnt));
  endtask

  task automatic drive(input logic v, input logic w, input logic [1:0] sel,
                       input logic [RAW-1:0] rd, input logic [DW-1:0] alu,
                       input logic [DW-1:0] mem, input logic [DW-1:0] pc4,
                       input logic st, input logic fl, input logic clr);
    MEM_Valid = v; MEM_RegWr = w; MEM_MemtoReg = sel; MEM_Rd = rd;
    ALU_OUT = alu; DATAMEM_READ = mem; MEM_PC4 = pc4;
    stall = st; flush = fl; cnt_clr = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic v, input logic w, input logic [1:0] sel,
                     input logic [RAW-1:0] rd, input logic [DW-1:0] alu,
                     input logic [DW-1:0] mem, input logic [DW-1:0] pc4,
                     input logic st, input logic fl, input logic clr,
                     input logic ev, input logic ew, input logic [RAW-1:0] erd,
                     input logic [DW-1:0] edata, input logic [CNT_W-1:0] ecnt);
    vec_t t;
    t.v = v; t.w = w; t.sel = sel; t.rd = rd; t.alu = alu; t.mem = mem; t.pc4 = pc4;
    t.st = st; t.fl = fl; t.clr = clr;
    t.e_v = ev; t.e_w = ew; t.e_rd = erd; t.e_data = edata; t.e_cnt = ecnt;
    vecs.push_back(t);
  endtask

  initial begin
    //   v  w  sel   rd  alu           mem           pc4           st fl clr  ev ew erd edata         cnt
    add(1, 1, 2'b00, 5, 32'h00000010, 32'h0,        32'h0,        0, 0, 0,  1, 1, 5, 32'h00000010, 4'd1);
    add(1, 1, 2'b01, 6, 32'h00001234, 32'hFFFFFF80, 32'h0,        0, 0, 0,  1, 1, 6, 32'hFFFFFF80, 4'd2);
    add(1, 1, 2'b10, 1, 32'h00000000, 32'h0,        32'h00003004, 0, 0, 0,  1, 1, 1, 32'h00003004, 4'd3);
    add(1, 1, 2'b11, 2, 32'h00000007, 32'h99,       32'h55,       0, 0, 0,  1, 1, 2, 32'h00000007, 4'd4);
    add(1, 1, 2'b00, 0, 32'h00000042, 32'h0,        32'h0,        0, 0, 0,  1, 0, 0, 32'h00000042, 4'd5);
    add(0, 1, 2'b00, 7, 32'h00000011, 32'h0,        32'h0,        0, 0, 0,  0, 0, 7, 32'h00000011, 4'd5);
    add(1, 0, 2'b00, 8, 32'h00000022, 32'h0,        32'h0,        0, 0, 0,  1, 0, 8, 32'h00000022, 4'd6);
    add(1, 1, 2'b01, 9, 32'h00000033, 32'h44,       32'h0,        0, 1, 0,  0, 0, 0, 32'h00000000, 4'd6);
    add(1, 1, 2'b00, 3, 32'h000000AA, 32'h0,        32'h0,        0, 0, 0,  1, 1, 3, 32'h000000AA, 4'd7);
    add(1, 1, 2'b00, 9, 32'h000000BB, 32'h0,        32'h0,        1, 1, 0,  0, 0, 0, 32'h00000000, 4'd7);
    add(1, 1, 2'b00, 3, 32'h000000AA, 32'h0,        32'h0,        0, 0, 0,  1, 1, 3, 32'h000000AA, 4'd8);
    add(1, 1, 2'b00, 9, 32'h000000BB, 32'h0,        32'h0,        1, 0, 0,  1, 1, 3, 32'h000000AA, 4'd8);
    add(1, 1, 2'b01, 9, 32'h000000BB, 32'hCC,       32'h0,        1, 0, 0,  1, 1, 3, 32'h000000AA, 4'd8);
    add(1, 1, 2'b00, 9, 32'h000000BB, 32'h0,        32'h0,        1, 0, 0,  1, 1, 3, 32'h000000AA, 4'd8);
    add(1, 1, 2'b00, 9, 32'h000000BB, 32'h0,        32'h0,        0, 0, 0,  1, 1, 9, 32'h000000BB, 4'd9);
    add(1, 1, 2'b00, 4, 32'h00000005, 32'h0,        32'h0,        0, 0, 1,  1, 1, 4, 32'h00000005, 4'd0);
    add(0, 0, 2'b00, 4, 32'h00000005, 32'h0,        32'h0,        1, 0, 1,  1, 1, 4, 32'h00000005, 4'd0);

    rst_n = 1'b0;
    drive(1'($urandom), 1'($urandom), 2'($urandom), RAW'($urandom), $urandom, $urandom,
          $urandom, 1'b0, 1'b0, 1'b0);
    repeat (3) begin
      step();
      drive(1'($urandom), 1'($urandom), 2'($urandom), RAW'($urandom), $urandom, $urandom,
            $urandom, 1'($urandom), 1'b0, 1'b0);
    end
    check_outs("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].w, vecs[i].sel, vecs[i].rd, vecs[i].alu, vecs[i].mem,
            vecs[i].pc4, vecs[i].st, vecs[i].fl, vecs[i].clr);
      step();
      check_outs($sformatf("v%0d", i), vecs[i].e_v, vecs[i].e_w, vecs[i].e_rd,
                 vecs[i].e_data, vecs[i].e_cnt);
    end

    // Reset asserted in the middle of a stall clears everything without a clock edge.
    drive(1, 1, 2'b00, 10, 32'h77, 0, 0, 0, 0, 0);
    step();
    check_outs("pre_rst", 1, 1, 10, 32'h77, 4'd1);
    drive(1, 1, 2'b00, 11, 32'h88, 0, 0, 1, 0, 0);
    step();
    #2 rst_n = 1'b0;
    #1 check_outs("mid_rst", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_outs("post_rst", 0, 0, 0, 0, 0);

    // Counter wrap on a 4-bit counter, then clear racing an increment.
    drive(1, 1, 2'b00, 1, 32'h1, 0, 0, 0, 0, 0);
    repeat (15) step();
    chk("cnt_full", 64'(RETIRE_CNT), 64'hF);
    step();
    chk("cnt_wrap", 64'(RETIRE_CNT), 64'h0);
    repeat (2) step();
    chk("cnt_two", 64'(RETIRE_CNT), 64'h2);
    cnt_clr = 1'b1;
    step();
    chk("cnt_clr", 64'(RETIRE_CNT), 64'h0);
    chk("clr_wb_valid", 64'(WB_Valid), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
